// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared types and sizes for the fetch-to-decode instruction queue.
//   fiq_entry_t : one queued instruction with its PC, PC+4 and the
//                 branch-prediction metadata that travels with it to decode.
//   FIQ_*       : default geometry used by the queue, its interface and storage.
// Optional feature macro used by the queue: FETCH_INSTR_QUEUE_BYPASS_EN.
package fetch_queue_pkg;

  localparam int FIQ_DEPTH   = 4;
  localparam int FIQ_ADDR_W  = 64;
  localparam int FIQ_INSTR_W = 32;
  localparam int FIQ_BTB_W   = 2;
  localparam int FIQ_PTR_W   = $clog2(FIQ_DEPTH);

  typedef struct packed {
    logic [FIQ_INSTR_W-1:0] instr;
    logic [FIQ_ADDR_W-1:0]  pc;
    logic [FIQ_ADDR_W-1:0]  pc_plus4;
    logic [FIQ_ADDR_W-1:0]  pc_target_pred;
    logic [FIQ_BTB_W-1:0]   btb_way;
    logic                   branch_taken_pred;
  } fiq_entry_t;

endpackage

// File: rtl/fetch_instr_queue_if.sv
// fetch_instr_queue_if
// Bundles the fetch-side push port, the decode-side pop port and the
// execute-side flush of the instruction queue.
//   Fetch side  : i_push, i_instr, i_pc, i_pc_plus4, i_pc_target_pred,
//                 i_btb_way, i_branch_taken_pred -> queue; o_ready <- queue
//   Decode side : i_pop -> queue; o_valid, o_instr, o_pc, o_pc_plus4,
//                 o_pc_target_pred, o_btb_way, o_branch_taken_pred, o_count <- queue
//   Execute     : i_flush -> queue
// Modports: master = the pipeline around the queue, slave = the queue itself.
interface fetch_instr_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH       = FIQ_DEPTH,
  parameter int ADDR_WIDTH  = FIQ_ADDR_W,
  parameter int INSTR_WIDTH = FIQ_INSTR_W
);

  logic                     i_flush;

  logic                     i_push;
  logic [INSTR_WIDTH-1:0]   i_instr;
  logic [ADDR_WIDTH-1:0]    i_pc;
  logic [ADDR_WIDTH-1:0]    i_pc_plus4;
  logic [ADDR_WIDTH-1:0]    i_pc_target_pred;
  logic [1:0]               i_btb_way;
  logic                     i_branch_taken_pred;
  logic                     o_ready;

  logic                     i_pop;
  logic                     o_valid;
  logic [INSTR_WIDTH-1:0]   o_instr;
  logic [ADDR_WIDTH-1:0]    o_pc;
  logic [ADDR_WIDTH-1:0]    o_pc_plus4;
  logic [ADDR_WIDTH-1:0]    o_pc_target_pred;
  logic [1:0]               o_btb_way;
  logic                     o_branch_taken_pred;
  logic [$clog2(DEPTH):0]   o_count;

  modport master (
    output i_flush, i_push, i_instr, i_pc, i_pc_plus4, i_pc_target_pred,
           i_btb_way, i_branch_taken_pred, i_pop,
    input  o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_pc_target_pred,
           o_btb_way, o_branch_taken_pred, o_count
  );

  modport slave (
    input  i_flush, i_push, i_instr, i_pc, i_pc_plus4, i_pc_target_pred,
           i_btb_way, i_branch_taken_pred, i_pop,
    output o_ready, o_valid, o_instr, o_pc, o_pc_plus4, o_pc_target_pred,
           o_btb_way, o_branch_taken_pred, o_count
  );

endinterface

// File: rtl/fiq_storage.sv
// fiq_storage
// Entry array of the instruction queue: DEPTH registers of fiq_entry_t with
// one synchronous write port and one asynchronous read port. Data is not
// reset; validity is tracked by the queue's count.
//   clk_i           : clock
//   we_i, waddr_i, wdata_i : write port, captured on the rising edge
//   raddr_i, rdata_o       : combinational read port
module fiq_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FIQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  fiq_entry_t       wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output fiq_entry_t       rdata_o
);

  fiq_entry_t mem_q [DEPTH];

  // Write port: a single entry is updated per cycle.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue
// Decoupling FIFO between fetch and decode. Holds fetched instructions with
// PC, PC+4 and branch-prediction metadata, absorbs decode stalls and I-cache
// bubbles, and drops everything in flight on a branch mispredict flush.
//   i_clk  : clock, all state updates on the rising edge
//   i_arst : asynchronous active-low reset (release expected to be
//            synchronised to i_clk outside this block)
//   bus    : fetch_instr_queue_if.slave carrying push/pop/flush, o_ready,
//            o_valid, head entry fields and o_count
// Optional feature: define FETCH_INSTR_QUEUE_BYPASS_EN to let a push into an
// empty queue appear at the head in the same cycle.
module fetch_instr_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH       = FIQ_DEPTH,
  parameter int ADDR_WIDTH  = FIQ_ADDR_W,
  parameter int INSTR_WIDTH = FIQ_INSTR_W
) (
  input  logic                i_clk,
  input  logic                i_arst,
  fetch_instr_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic       stateValid;
  logic       notFull;
  logic       pushAcc;
  logic       popAcc;
  logic       writeEn;
  logic       bypassLive;
  logic       bypassHit;
  fiq_entry_t wrEntry;
  fiq_entry_t rdEntry;
  fiq_entry_t headEntry;

  // Handshake status depends only on registered occupancy, so o_ready has no
  // path from i_pop.
  assign stateValid = (count_q != '0);
  assign notFull    = (count_q != CNT_W'(DEPTH));

  assign pushAcc = bus.i_push & notFull & ~bus.i_flush;
  assign popAcc  = bus.i_pop & stateValid & ~bus.i_flush;

`ifdef FETCH_INSTR_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming entry straight to the head; if
  // decode takes it in the same cycle it is never written.
  assign bypassLive = (count_q == '0) & bus.i_push & ~bus.i_flush;
  assign bypassHit  = bypassLive & bus.i_pop;
`else
  assign bypassLive = 1'b0;
  assign bypassHit  = 1'b0;
`endif

  assign writeEn = pushAcc & ~bypassHit;

  assign wrEntry = '{
    instr:             bus.i_instr,
    pc:                bus.i_pc,
    pc_plus4:          bus.i_pc_plus4,
    pc_target_pred:    bus.i_pc_target_pred,
    btb_way:           bus.i_btb_way,
    branch_taken_pred: bus.i_branch_taken_pred
  };

  fiq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk_i   (i_clk),
    .we_i    (writeEn),
    .waddr_i (wrPtr_q),
    .wdata_i (wrEntry),
    .raddr_i (rdPtr_q),
    .rdata_o (rdEntry)
  );

  // Next-state for pointers and occupancy. Flush wins over any same-cycle
  // push or pop; a full queue rejects a push even when a pop frees a slot.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (bus.i_flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (writeEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popAcc) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(writeEn) - CNT_W'(popAcc);
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Head data is zeroed while empty so the unreset storage never leaks out.
  always_comb begin
    headEntry = '0;
    if (bypassLive) begin
      headEntry = wrEntry;
    end else if (stateValid) begin
      headEntry = rdEntry;
    end
  end

  assign bus.o_ready             = notFull;
  assign bus.o_valid             = stateValid | bypassLive;
  assign bus.o_count             = count_q;
  assign bus.o_instr             = headEntry.instr;
  assign bus.o_pc                = headEntry.pc;
  assign bus.o_pc_plus4          = headEntry.pc_plus4;
  assign bus.o_pc_target_pred    = headEntry.pc_target_pred;
  assign bus.o_btb_way           = headEntry.btb_way;
  assign bus.o_branch_taken_pred = headEntry.branch_taken_pred;

endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue
// Directed bench for fetch_instr_queue (DEPTH=4). Inputs are driven 1 time
// unit after the rising edge and outputs are checked before the next edge.
// Follows FETCH_INSTR_QUEUE_BYPASS_EN when it is defined for the build.
module tb_fetch_instr_queue;
  import fetch_queue_pkg::*;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 clk = ~clk;

  fetch_instr_queue_if #(.DEPTH(4), .ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  fetch_instr_queue #(.DEPTH(4), .ADDR_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus.slave)
  );

  // Instruction word derived from a PC so each entry is distinguishable.
  function automatic logic [31:0] instrOf(input logic [63:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic pop, input logic flush,
                               input logic [63:0] pc, input logic [31:0] instr);
    bus.i_push              = push;
    bus.i_pop               = pop;
    bus.i_flush             = flush;
    bus.i_pc                = pc;
    bus.i_instr             = instr;
    bus.i_pc_plus4          = pc + 64'd4;
    bus.i_pc_target_pred    = pc + 64'h100;
    bus.i_btb_way           = pc[3:2];
    bus.i_branch_taken_pred = pc[2];
  endtask

  // Advance past one rising edge, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  initial begin
    logic [63:0] pc;
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    #3;
    checkOutput("reset_valid", bus.o_valid, 64'd0);
    checkOutput("reset_ready", bus.o_ready, 64'd1);
    checkOutput("reset_count", bus.o_count, 64'd0);
    checkOutput("reset_pc",    bus.o_pc,    64'd0);
    checkOutput("reset_instr", bus.o_instr, 64'd0);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk);
    #1;

    // Single push becomes visible one cycle later.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h1000, 32'h00500093);
`ifndef FETCH_INSTR_QUEUE_BYPASS_EN
    #1;
    checkOutput("t1_no_same_cycle_valid", bus.o_valid, 64'd0);
`endif
    tick();
    checkOutput("t1_valid", bus.o_valid, 64'd1);
    checkOutput("t1_pc",    bus.o_pc,    64'h1000);
    checkOutput("t1_instr", bus.o_instr, 64'h00500093);
    checkOutput("t1_plus4", bus.o_pc_plus4, 64'h1004);
    checkOutput("t1_count", bus.o_count, 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    tick();
    checkOutput("t1_drained", bus.o_valid, 64'd0);

    // Fill to full, reject a fifth push, drain in order.
    for (int i = 0; i < 4; i++) begin
      pc = 64'h1000 + 64'(4 * i);
      applyStimulus(1'b1, 1'b0, 1'b0, pc, instrOf(pc));
      tick();
    end
    checkOutput("t2_full_ready", bus.o_ready, 64'd0);
    checkOutput("t2_full_count", bus.o_count, 64'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h1010, instrOf(64'h1010));
    tick();
    checkOutput("t2_reject_count", bus.o_count, 64'd4);
    checkOutput("t2_head_pc", bus.o_pc, 64'h1000);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_pop%0d_pc", i), bus.o_pc, 64'h1000 + 64'(4 * i));
      if (i == 1) begin
        checkOutput("t2_instr_1004",  bus.o_instr, 64'h10040013);
        checkOutput("t2_target_1004", bus.o_pc_target_pred, 64'h1104);
        checkOutput("t2_btbway_1004", bus.o_btb_way, 64'd1);
        checkOutput("t2_taken_1004",  bus.o_branch_taken_pred, 64'd1);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
      tick();
    end
    checkOutput("t2_empty_valid", bus.o_valid, 64'd0);
    checkOutput("t2_empty_count", bus.o_count, 64'd0);

    // Steady push+pop at occupancy 2; pointers wrap several times.
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h5000, instrOf(64'h5000));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h5004, instrOf(64'h5004));
    tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t3_step%0d_pc", i), bus.o_pc, 64'h5000 + 64'(4 * i));
      checkOutput($sformatf("t3_step%0d_count", i), bus.o_count, 64'd2);
      pc = 64'h5008 + 64'(4 * i);
      applyStimulus(1'b1, 1'b1, 1'b0, pc, instrOf(pc));
      tick();
    end
    checkOutput("t3_after_count", bus.o_count, 64'd2);
    checkOutput("t3_after_pc0", bus.o_pc, 64'h5028);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    tick();
    checkOutput("t3_after_pc1", bus.o_pc, 64'h502C);
    checkOutput("t3_after_instr1", bus.o_instr, 64'h502C0013);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    tick();
    checkOutput("t3_empty_valid", bus.o_valid, 64'd0);

    // Flush beats a same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      pc = 64'h6000 + 64'(4 * i);
      applyStimulus(1'b1, 1'b0, 1'b0, pc, instrOf(pc));
      tick();
    end
    checkOutput("t4_pre_count", bus.o_count, 64'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h2000, instrOf(64'h2000));
    tick();
    checkOutput("t4_flush_count", bus.o_count, 64'd0);
    checkOutput("t4_flush_valid", bus.o_valid, 64'd0);
    checkOutput("t4_flush_ready", bus.o_ready, 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h3000, instrOf(64'h3000));
    tick();
    checkOutput("t4_post_pc",    bus.o_pc,    64'h3000);
    checkOutput("t4_post_count", bus.o_count, 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h3004, instrOf(64'h3004));
    tick();
    checkOutput("t5_pre_count", bus.o_count, 64'd2);

    // Asynchronous reset mid-cycle clears state before the next edge.
    #2;
    arst = 1'b0;
    #1;
    checkOutput("t5_async_valid", bus.o_valid, 64'd0);
    checkOutput("t5_async_count", bus.o_count, 64'd0);
    checkOutput("t5_async_pc",    bus.o_pc,    64'd0);
    tick();
    arst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h7000, instrOf(64'h7000));
    tick();
    checkOutput("t5_post_pc",    bus.o_pc,    64'h7000);
    checkOutput("t5_post_instr", bus.o_instr, 64'h70000013);
    checkOutput("t5_post_count", bus.o_count, 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 32'h0);
    tick();
    checkOutput("t5_drained", bus.o_valid, 64'd0);

    // Push with pop into an empty queue.
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h4000, instrOf(64'h4000));
    #1;
`ifdef FETCH_INSTR_QUEUE_BYPASS_EN
    checkOutput("t6_bypass_valid", bus.o_valid, 64'd1);
    checkOutput("t6_bypass_pc",    bus.o_pc,    64'h4000);
    tick();
    checkOutput("t6_bypass_count", bus.o_count, 64'd0);
    checkOutput("t6_bypass_after_valid", bus.o_valid, 64'd0);
`else
    checkOutput("t6_nobypass_valid", bus.o_valid, 64'd0);
    checkOutput("t6_nobypass_pc",    bus.o_pc,    64'd0);
    tick();
    checkOutput("t6_nobypass_count", bus.o_count, 64'd1);
    checkOutput("t6_nobypass_head",  bus.o_pc,    64'h4000);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
